// File: rtl/std_fifo_stream_out_if.sv
// Handshake bundle between std_fifo, the stream-out stage and its consumer.
// master = stream-out stage; slave = the FIFO/consumer side.
interface std_fifo_stream_out_if #(
  parameter int WIDTH = 8
);
  logic             fifo_empty;
  logic             fifo_pop;
  logic [WIDTH-1:0] fifo_q;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    input  fifo_empty,
    input  fifo_q,
    input  out_ready,
    output fifo_pop,
    output out_valid,
    output out_data
  );

  modport slave (
    output fifo_empty,
    output fifo_q,
    output out_ready,
    input  fifo_pop,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/std_fifo_stream_out.sv
// std_fifo drain stage: pop/q (1-cycle latency) to FWFT valid/ready stream.
// Optional counters under `STD_FIFO_STREAM_OUT_STATS_EN.
module std_fifo_stream_out #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  std_fifo_stream_out_if.master bus
`ifdef STD_FIFO_STREAM_OUT_STATS_EN
  ,
  output logic [31:0]           o_xfer_count,
  output logic [31:0]           o_stall_count
`endif
);

  logic [WIDTH-1:0] r_buf [2];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic             r_inflight;
  logic [1:0]       r_cnt;

  logic             w_valid;
  logic             w_take;
  logic             w_pop;
  logic [2:0]       w_occ;
  logic [1:0]       w_cnt_nxt;

  // Pop only if the word still fits once this cycle's take frees a slot.
  always_comb begin
    w_valid   = (r_cnt != 2'd0);
    w_take    = w_valid && bus.out_ready;
    w_occ     = {1'b0, r_cnt}
              + {2'b00, r_inflight}
              - {2'b00, w_take};
    w_pop     = !bus.fifo_empty && (w_occ < 3'd2);
    w_cnt_nxt = r_cnt
              + {1'b0, r_inflight}
              - {1'b0, w_take};
  end

  assign bus.fifo_pop  = w_pop;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = r_buf[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_cnt      <= 2'd0;
    end else begin
      r_inflight <= w_pop;
      r_cnt      <= w_cnt_nxt;
      if (r_inflight) r_wr_ptr <= ~r_wr_ptr;
      if (w_take)     r_rd_ptr <= ~r_rd_ptr;
    end
  end

  // Data slots carry no reset; r_cnt alone says what is live.
  always_ff @(posedge clk) begin
    if (r_inflight) r_buf[r_wr_ptr] <= bus.fifo_q;
  end

`ifdef STD_FIFO_STREAM_OUT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_xfer_count  <= 32'd0;
      o_stall_count <= 32'd0;
    end else begin
      if (w_take)
        o_xfer_count <= o_xfer_count + 32'd1;
      if (w_valid && !bus.out_ready)
        o_stall_count <= o_stall_count + 32'd1;
    end
  end
`endif

endmodule
